la_capture_ctrl: RTL and testbench
==================================

Name: la_capture_ctrl

Overview:
- Capture sequencer for the tiny logic analyzer: arms the pattern trigger, records pre- and post-trigger samples of the 4-bit probe bus into a circular sample buffer, then streams the window out via a request/valid handshake.
- Sits between the probe inputs / sample-rate strobe and the host-facing readout logic. Exposes an 8-bit status byte in the same format as other analyzer status outputs.

Parameters:
- DEPTH, 16, sample buffer entries; power of two, 4..64.
- AW, 4, buffer address width; equals log2(DEPTH).
- DW, 4, probe/sample width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a capture from IDLE
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- sample_en  in  1  sample strobe (prescaler); buffer writes and trigger checks happen only when it is 1
- in_data  in  DW  probe bus
- trig_mask  in  DW  trigger care bits; latched at start
- trig_value  in  DW  trigger pattern; latched at start
- pre_count  in  AW  number of pre-trigger samples, 0..DEPTH-1; latched at start
- rd_req  in  1  readout request, one sample per cycle high
- rd_valid  out  1  rd_data valid
- rd_data  out  DW  readout sample
- rd_last  out  1  marks the DEPTH-th sample, qualified by rd_valid
- busy  out  1  state is not IDLE
- done  out  1  capture complete, window readable
- status  out  8  {3'b0, state[2:0], done, triggered}

Behaviour:
- Reset: state IDLE. rd_valid, rd_data, rd_last, busy, done, status, all pointers and counters are 0. Buffer contents are undefined.
- States: IDLE=0, PRETRIG=1, WAIT_TRIG=2, POSTTRIG=3, DONE=4.
- IDLE:
  - start latches mask, value and pre_count, clears wr_ptr and triggered.
  - Next state is PRETRIG if pre_count>0, else WAIT_TRIG.
- Writes: in PRETRIG, WAIT_TRIG and POSTTRIG, every sample_en cycle writes in_data at wr_ptr on that edge, then wr_ptr increments mod DEPTH.
- PRETRIG: counts pre_count writes, then goes to WAIT_TRIG. The trigger is not evaluated in PRETRIG.
- WAIT_TRIG:
  - Match condition: (in_data & mask) == (value & mask) on a sample_en cycle. mask=0 matches the first eligible sample.
  - The matching sample is written at trig_addr = wr_ptr, which is recorded.
  - triggered goes 1 on the next cycle. The trigger sample counts as window sample 0.
  - Next state is POSTTRIG, or DONE directly if DEPTH-1-pre_count == 0.
- POSTTRIG: performs DEPTH-1-pre_count further writes, then goes to DONE. done asserts the cycle DONE is entered.
- Window: exactly DEPTH samples, oldest first. The read pointer starts at (trig_addr - pre_count) mod DEPTH with wrap-around.
- Readout, in DONE only:
  - rd_req high in cycle N gives rd_valid=1 in cycle N+1 with the next sample; the pointer advances mod DEPTH.
  - rd_req while rd_valid is high is legal (back-to-back, 1 sample/cycle).
  - rd_req outside DONE is ignored and rd_valid stays 0.
- End of readout: rd_last=1 with the DEPTH-th sample. The cycle after it, the state goes to IDLE, and done and triggered clear.
- Extra rd_req after the last sample is issued is ignored.
- start while busy is ignored.
- abort in any state goes to IDLE next cycle: done, triggered and rd_valid clear, and any readout is truncated. abort takes priority over start and rd_req in the same cycle.
- sample_en=0 freezes all capture counters. Trigger matches are not seen while sample_en=0.
- The trigger output is level (triggered) for the rest of the capture. Status reflects registered state with no combinational input path.
- Reset mid-capture or mid-readout: immediate return to reset values.

Optional Feature:
- Macro: LA_EDGE_TRIG_EN.
- With the macro:
  - Adds input trig_edge (1 bit, latched at start) and a register holding the previous sampled in_data.
  - When trig_edge=1, the match is ((in_data ^ prev) & mask) != 0 on a sample_en cycle, i.e. any change on a cared bit.
  - prev updates on every sample_en cycle in any capture state. The first WAIT_TRIG sample after start with pre_count=0 never edge-matches.
- Without the macro: no trig_edge port, pattern matching only.

Decomposition:
- Package la_pkg: state encoding constants (LA_IDLE..LA_DONE), status bit positions, DEPTH default.
- Sub-module la_sample_ram: DEPTH x DW, one synchronous write port and one synchronous read port with 1-cycle read latency. Its read latency provides the rd_valid alignment.

Test Plan:
- DEPTH=16: start with mask=4'hF, value=4'hA, pre_count=4, sample_en=1, incrementing in_data from 0 -> triggered 1 cycle after in_data=A; done after 11 more samples; readout gives 6,7,8,9,A,B..F,0,1,2,3,4,5 with rd_last on the 16th sample.
- pre_count=0, mask=0 -> trigger on the first sample; window is 16 samples starting at the trigger sample.
- pre_count=15 -> DONE entered the cycle after the trigger; readout ends with the trigger sample as the 16th (rd_last).
- sample_en toggling 1/0 -> counts advance only on strobe cycles; a match while sample_en=0 is not triggered.
- abort during WAIT_TRIG and during readout -> IDLE next cycle, status=8'h00, rd_valid=0; start while busy has no effect.
- LA_EDGE_TRIG_EN, trig_edge=1, mask=4'h1, in_data held at 4'h0 then 4'h1 -> triggered only after the 0->1 transition on bit 0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture sequencer: state encoding,
// status byte layout and the default buffer depth.
package la_pkg;

   localparam int LA_DEPTH_DEF = 16;

   typedef enum logic [2:0] {
      LA_IDLE      = 3'd0,
      LA_PRETRIG   = 3'd1,
      LA_WAIT_TRIG = 3'd2,
      LA_POSTTRIG  = 3'd3,
      LA_DONE      = 3'd4
   } la_state_t;

   // Status byte: {3'b0, state[2:0], done, triggered}
   localparam int LA_ST_TRIG     = 0;
   localparam int LA_ST_DONE     = 1;
   localparam int LA_ST_STATE_LO = 2;
   localparam int LA_ST_STATE_HI = 4;

   function automatic logic [7:0] la_status(input la_state_t st, input logic dn,
                                             input logic trg);
      logic [7:0] s;
      s = 8'h00;
      s[LA_ST_STATE_HI:LA_ST_STATE_LO] = st;
      s[LA_ST_DONE] = dn;
      s[LA_ST_TRIG] = trg;
      return s;
   endfunction

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Readout port of the capture sequencer; the host side is the master.
// rd_req is a request, not a valid/ready pair: each cycle rd_req is high while the
// window is readable, exactly one sample comes back the next cycle with rd_valid=1.
interface la_capture_ctrl_if #(parameter int DW = 4) ();
   logic          rd_req;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_last;

   modport master (output rd_req, input rd_valid, rd_data, rd_last);
   modport slave  (input rd_req, output rd_valid, rd_data, rd_last);
endinterface

// File: rtl/la_sample_ram.sv
// Circular sample buffer: one synchronous write port, one registered read port
// (1-cycle latency, read data register resets to 0).
module la_sample_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: pre/post-trigger recording into a circular buffer and window readout.
// Optional edge trigger enabled by defining LA_EDGE_TRIG_EN (adds the trig_edge input).
module la_capture_ctrl
   import la_pkg::*;
#(
   parameter int DEPTH = LA_DEPTH_DEF,
   parameter int AW    = 4,
   parameter int DW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             sample_en,
   input  logic [DW-1:0]    in_data,
   input  logic [DW-1:0]    trig_mask,
   input  logic [DW-1:0]    trig_value,
   input  logic [AW-1:0]    pre_count,
`ifdef LA_EDGE_TRIG_EN
   input  logic             trig_edge,
`endif
   la_capture_ctrl_if.slave rd,
   output logic             busy,
   output logic             done,
   output logic [7:0]       status
);

   localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);
   localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);

   la_state_t     r_state;
   logic [DW-1:0] r_mask, r_value;
   logic [AW-1:0] r_pre, r_wr_ptr, r_cnt, r_rd_ptr;
   logic [AW:0]   r_rd_cnt;
   logic          r_triggered, r_done, r_rd_valid, r_rd_last;

   logic          w_capturing, w_we, w_match, w_pat_match, w_rd_issue;
   logic [AW-1:0] w_post_m1;

   assign w_capturing = (r_state == LA_PRETRIG) || (r_state == LA_WAIT_TRIG) ||
                        (r_state == LA_POSTTRIG);
   assign w_we        = w_capturing && sample_en;
   assign w_pat_match = ((in_data & r_mask) == (r_value & r_mask));
   // Index of the final post-trigger write (DEPTH-1-pre writes after the trigger)
   assign w_post_m1   = LP_LAST - r_pre - AW'(1);
   assign w_rd_issue  = (r_state == LA_DONE) && rd.rd_req && (r_rd_cnt != LP_DEPTH) && !abort;

`ifdef LA_EDGE_TRIG_EN
   logic          r_edge, r_prev_vld;
   logic [DW-1:0] r_prev;
   logic          w_edge_match;
   // No edge can be seen until one sample of this capture has been recorded
   assign w_edge_match = r_prev_vld && (|((in_data ^ r_prev) & r_mask));
   assign w_match      = r_edge ? w_edge_match : w_pat_match;
`else
   assign w_match      = w_pat_match;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LA_IDLE;
         r_mask      <= '0;
         r_value     <= '0;
         r_pre       <= '0;
         r_wr_ptr    <= '0;
         r_cnt       <= '0;
         r_rd_ptr    <= '0;
         r_rd_cnt    <= '0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
`ifdef LA_EDGE_TRIG_EN
         r_edge      <= 1'b0;
         r_prev_vld  <= 1'b0;
         r_prev      <= '0;
`endif
      end else if (abort) begin
         r_state     <= LA_IDLE;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_issue;
         r_rd_last  <= w_rd_issue && (r_rd_cnt == LP_DEPTH - (AW+1)'(1));
         if (w_we) r_wr_ptr <= r_wr_ptr + AW'(1);
`ifdef LA_EDGE_TRIG_EN
         if (w_we) begin
            r_prev     <= in_data;
            r_prev_vld <= 1'b1;
         end
`endif
         case (r_state)
            LA_IDLE: begin
               if (start) begin
                  r_mask      <= trig_mask;
                  r_value     <= trig_value;
                  r_pre       <= pre_count;
                  r_wr_ptr    <= '0;
                  r_cnt       <= '0;
                  r_rd_cnt    <= '0;
                  r_triggered <= 1'b0;
                  r_done      <= 1'b0;
`ifdef LA_EDGE_TRIG_EN
                  r_edge      <= trig_edge;
                  r_prev_vld  <= 1'b0;
`endif
                  r_state     <= (pre_count != '0) ? LA_PRETRIG : LA_WAIT_TRIG;
               end
            end
            LA_PRETRIG: begin
               if (sample_en) begin
                  r_cnt <= r_cnt + AW'(1);
                  if (r_cnt == r_pre - AW'(1)) begin
                     r_cnt   <= '0;
                     r_state <= LA_WAIT_TRIG;
                  end
               end
            end
            LA_WAIT_TRIG: begin
               if (sample_en && w_match) begin
                  // Window starts pre samples before the trigger address, wrapping
                  r_rd_ptr    <= r_wr_ptr - r_pre;
                  r_triggered <= 1'b1;
                  r_cnt       <= '0;
                  if (r_pre == LP_LAST) begin
                     r_state <= LA_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= LA_POSTTRIG;
                  end
               end
            end
            LA_POSTTRIG: begin
               if (sample_en) begin
                  r_cnt <= r_cnt + AW'(1);
                  if (r_cnt == w_post_m1) begin
                     r_state <= LA_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            LA_DONE: begin
               if (w_rd_issue) begin
                  r_rd_ptr <= r_rd_ptr + AW'(1);
                  r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
               end
               if (r_rd_valid && r_rd_last) begin
                  r_state     <= LA_IDLE;
                  r_done      <= 1'b0;
                  r_triggered <= 1'b0;
               end
            end
            default: r_state <= LA_IDLE;
         endcase
      end
   end

   la_sample_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (in_data),
      .i_re    (w_rd_issue),
      .i_raddr (r_rd_ptr),
      .o_rdata (rd.rd_data)
   );

   assign rd.rd_valid = r_rd_valid;
   assign rd.rd_last  = r_rd_last;
   assign busy        = (r_state != LA_IDLE);
   assign done        = r_done;
   assign status      = la_status(r_state, r_done, r_triggered);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl: per-scenario tasks plus a readout scoreboard.
module tb_la_capture_ctrl;
   import la_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          sample_en = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [DW-1:0] trig_mask = '0;
   logic [DW-1:0] trig_value = '0;
   logic [AW-1:0] pre_count = '0;
`ifdef LA_EDGE_TRIG_EN
   logic          trig_edge = 1'b0;
`endif
   logic          busy, done;
   logic [7:0]    status;

   int errors = 0;
   int checks = 0;
   logic [DW:0] exp_q[$];

   la_capture_ctrl_if #(.DW(DW)) rd_if ();

   la_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .sample_en  (sample_en),
      .in_data    (in_data),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .pre_count  (pre_count),
`ifdef LA_EDGE_TRIG_EN
      .trig_edge  (trig_edge),
`endif
      .rd         (rd_if.slave),
      .busy       (busy),
      .done       (done),
      .status     (status)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [DW:0] exp;
      if (rst_n && rd_if.rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got data=%h last=%b, required no output",
                     rd_if.rd_data, rd_if.rd_last);
         end else begin
            exp = exp_q.pop_front();
            if ({rd_if.rd_last, rd_if.rd_data} !== exp)
               begin
                  errors++;
                  $display("FAIL rd_sample: got data=%h last=%b, required data=%h last=%b",
                           rd_if.rd_data, rd_if.rd_last, exp[DW-1:0], exp[DW]);
               end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [DW-1:0] v, input logic en);
      in_data   = v;
      sample_en = en;
      tick();
   endtask

   task automatic start_capture(input logic [DW-1:0] m, input logic [DW-1:0] v,
                                input logic [AW-1:0] p);
      trig_mask  = m;
      trig_value = v;
      pre_count  = p;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Expected window: DEPTH consecutive probe values starting at base, last flag on the final one
   task automatic push_window(input int base, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i == DEPTH - 1), DW'((base + i) % DEPTH)});
   endtask

   task automatic readout(input int n);
      rd_if.rd_req = 1'b1;
      repeat (n) tick();
      rd_if.rd_req = 1'b0;
   endtask

   task automatic readout_gapped(input int n);
      for (int i = 0; i < n; i++) begin
         rd_if.rd_req = 1'b1;
         tick();
         rd_if.rd_req = 1'b0;
         tick();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      rd_if.rd_req = 1'b0;
      tick();
      checks++;
      if ({rd_if.rd_valid, rd_if.rd_last, busy, done} !== 4'b0000 || rd_if.rd_data !== '0 ||
          status !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b busy=%b done=%b data=%h status=%h, required all 0",
                  rd_if.rd_valid, rd_if.rd_last, busy, done, rd_if.rd_data, status);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      start_capture(4'hF, 4'hA, 4'd4);
      checks++;
      if (status !== 8'h04 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_pretrig: got status=%h busy=%b, required 04/1", status, busy);
      end
      for (int v = 0; v < 10; v++) feed(DW'(v), 1'b1);
      checks++;
      if (status !== 8'h08) begin
         errors++; $display("FAIL basic_waiting: got status=%h, required 08", status);
      end
      feed(4'hA, 1'b1);
      checks++;
      if (status !== 8'h0D) begin
         errors++; $display("FAIL basic_triggered: got status=%h, required 0D", status);
      end
      for (int k = 1; k <= 10; k++) feed(DW'((10 + k) % DEPTH), 1'b1);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL basic_done_early: got done=%b, required 0", done);
      end
      feed(4'h5, 1'b1);
      checks++;
      if (done !== 1'b1 || status !== 8'h13) begin
         errors++; $display("FAIL basic_done: got done=%b status=%h, required 1/13", done, status);
      end
      sample_en = 1'b0;
      push_window(6, DEPTH);
      readout(DEPTH);
      tick();
      checks++;
      if (exp_q.size() != 0 || status !== 8'h00 || done !== 1'b0) begin
         errors++; $display("FAIL basic_end: got pending=%0d status=%h done=%b, required 0/00/0",
                            exp_q.size(), status, done);
      end
   endtask

   task automatic test_pre0_mask0();
      start_capture(4'h0, 4'h0, 4'd0);
      checks++;
      if (status !== 8'h08) begin
         errors++; $display("FAIL pre0_wait: got status=%h, required 08", status);
      end
      feed(4'h3, 1'b1);
      checks++;
      if (status !== 8'h0D) begin
         errors++; $display("FAIL pre0_trig: got status=%h, required 0D", status);
      end
      for (int k = 0; k < 14; k++) feed(DW'((4 + k) % DEPTH), 1'b1);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL pre0_done_early: got done=%b, required 0", done);
      end
      feed(4'h2, 1'b1);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL pre0_done: got done=%b, required 1", done);
      end
      sample_en = 1'b0;
      push_window(3, DEPTH);
      readout(DEPTH);
      tick();
      checks++;
      if (exp_q.size() != 0 || status !== 8'h00) begin
         errors++; $display("FAIL pre0_end: got pending=%0d status=%h, required 0/00", exp_q.size(), status);
      end
   endtask

   task automatic test_pre15_back_to_back();
      start_capture(4'hF, 4'h5, 4'd15);
      for (int v = 0; v < 15; v++) feed(DW'(v), 1'b1);
      checks++;
      if (status !== 8'h08) begin
         errors++; $display("FAIL pre15_wait: got status=%h, required 08", status);
      end
      for (int v = 15; v < 21; v++) feed(DW'(v % DEPTH), 1'b1);
      feed(4'h5, 1'b1);
      checks++;
      if (done !== 1'b1 || status !== 8'h13) begin
         errors++; $display("FAIL pre15_done: got done=%b status=%h, required 1/13", done, status);
      end
      sample_en = 1'b0;
      push_window(6, DEPTH);
      readout(DEPTH + 2);
      checks++;
      if (exp_q.size() != 0 || status !== 8'h00 || rd_if.rd_valid !== 1'b0) begin
         errors++; $display("FAIL pre15_end: got pending=%0d status=%h valid=%b, required 0/00/0",
                            exp_q.size(), status, rd_if.rd_valid);
      end
   endtask

   task automatic test_sample_en();
      start_capture(4'hF, 4'h9, 4'd2);
      feed(4'h0, 1'b1);
      feed(4'h9, 1'b0);
      checks++;
      if (status !== 8'h04) begin
         errors++; $display("FAIL sen_pre_frozen: got status=%h, required 04", status);
      end
      feed(4'h1, 1'b1);
      for (int v = 2; v < 9; v++) begin
         feed(DW'(v), 1'b1);
         feed(4'h9, 1'b0);
      end
      checks++;
      if (status !== 8'h08) begin
         errors++; $display("FAIL sen_no_trig: got status=%h, required 08", status);
      end
      feed(4'h9, 1'b1);
      checks++;
      if (status !== 8'h0D) begin
         errors++; $display("FAIL sen_trig: got status=%h, required 0D", status);
      end
      for (int k = 1; k <= 12; k++) begin
         feed(DW'((9 + k) % DEPTH), 1'b1);
         feed(DW'($urandom_range(15, 0)), 1'b0);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL sen_done_early: got done=%b, required 0", done);
      end
      feed(4'h6, 1'b1);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL sen_done: got done=%b, required 1", done);
      end
      sample_en = 1'b0;
      push_window(7, DEPTH);
      readout_gapped(DEPTH);
      checks++;
      if (exp_q.size() != 0 || status !== 8'h00) begin
         errors++; $display("FAIL sen_end: got pending=%0d status=%h, required 0/00", exp_q.size(), status);
      end
   endtask

   task automatic test_abort();
      start_capture(4'hF, 4'h0, 4'd0);
      feed(4'h5, 1'b1);
      feed(4'h5, 1'b1);
      pre_count = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (status !== 8'h08) begin
         errors++; $display("FAIL abort_start_busy: got status=%h, required 08", status);
      end
      rd_if.rd_req = 1'b1;
      tick();
      tick();
      rd_if.rd_req = 1'b0;
      checks++;
      if (rd_if.rd_valid !== 1'b0) begin
         errors++; $display("FAIL abort_req_ignored: got valid=%b, required 0", rd_if.rd_valid);
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      checks++;
      if (status !== 8'h00 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_wait: got status=%h busy=%b, required 00/0", status, busy);
      end
      tick();
      checks++;
      if (status !== 8'h00) begin
         errors++; $display("FAIL abort_prio: got status=%h, required 00", status);
      end
      start_capture(4'h0, 4'h0, 4'd0);
      for (int k = 0; k < DEPTH; k++) feed(DW'(k), 1'b1);
      sample_en = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL abort_cap_done: got done=%b, required 1", done);
      end
      push_window(0, 5);
      readout(5);
      rd_if.rd_req = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      rd_if.rd_req = 1'b0;
      checks++;
      if (rd_if.rd_valid !== 1'b0 || status !== 8'h00 || done !== 1'b0) begin
         errors++; $display("FAIL abort_readout: got valid=%b status=%h done=%b, required 0/00/0",
                            rd_if.rd_valid, status, done);
      end
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL abort_pending: got pending=%0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      start_capture(4'hF, 4'hA, 4'd4);
      feed(4'h1, 1'b1);
      feed(4'h2, 1'b1);
      rst_n = 1'b0;
      #1;
      checks++;
      if (status !== 8'h00 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_capture: got status=%h busy=%b, required 00/0", status, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      start_capture(4'h0, 4'h0, 4'd0);
      for (int k = 0; k < DEPTH; k++) feed(DW'(k + 8), 1'b1);
      sample_en = 1'b0;
      push_window(8, 2);
      readout(3);
      rst_n = 1'b0;
      #1;
      checks++;
      if (rd_if.rd_valid !== 1'b0 || done !== 1'b0 || status !== 8'h00 || exp_q.size() != 0) begin
         errors++; $display("FAIL reset_mid_readout: got valid=%b done=%b status=%h pending=%0d, required 0/0/00/0",
                            rd_if.rd_valid, done, status, exp_q.size());
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

`ifdef LA_EDGE_TRIG_EN
   task automatic test_edge();
      trig_edge = 1'b1;
      start_capture(4'h1, 4'h0, 4'd0);
      trig_edge = 1'b0;
      for (int k = 0; k < 4; k++) feed(4'h0, 1'b1);
      checks++;
      if (status !== 8'h08) begin
         errors++; $display("FAIL edge_hold: got status=%h, required 08", status);
      end
      feed(4'h1, 1'b1);
      checks++;
      if (status !== 8'h0D) begin
         errors++; $display("FAIL edge_trig: got status=%h, required 0D", status);
      end
      for (int k = 2; k <= DEPTH; k++) feed(DW'(k % DEPTH), 1'b1);
      sample_en = 1'b0;
      push_window(1, DEPTH);
      readout(DEPTH);
      tick();
      checks++;
      if (exp_q.size() != 0 || status !== 8'h00) begin
         errors++; $display("FAIL edge_end: got pending=%0d status=%h, required 0/00", exp_q.size(), status);
      end
   endtask
`endif

   initial begin
      rd_if.rd_req = 1'b0;
      test_reset();
      test_basic();
      test_pre0_mask0();
      test_pre15_back_to_back();
      test_sample_en();
      test_abort();
      test_reset_mid();
`ifdef LA_EDGE_TRIG_EN
      test_edge();
`endif
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
